// File: rtl/delta_pkg.sv
// delta_pkg: shared sizes, element/delta types, FSM states and the tile-size helper
// for the delta input buffer.
package delta_pkg;

  localparam int INPUT_CHANNEL = 4;
  localparam int INPUT_HEIGHT  = 64;
  localparam int INPUT_WIDTH   = 64;
  localparam int ELEM_W        = 8;

  typedef logic [ELEM_W-1:0]        elem_t;
  typedef logic signed [ELEM_W:0]   delta_t;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FINISH} ib_state_t;

  // Tile edge T = 7*stride_eff + kernel_size; stride 0 behaves as 1.
  function automatic logic [6:0] calc_t(input logic [2:0] stride, input logic [3:0] kernel_size);
    logic [6:0] s;
    s = (stride == 3'd0) ? 7'd1 : {4'd0, stride};
    return (s << 3) - s + {3'd0, kernel_size};
  endfunction

endpackage

// File: rtl/delta_ib_bank.sv
// delta_ib_bank: one channel's tile storage. 8-element row-segment write port,
// two combinational element reads (current column and the left-stride neighbour).
module delta_ib_bank
  import delta_pkg::*;
#(
  parameter int NROW = INPUT_HEIGHT,
  parameter int NCOL = INPUT_WIDTH,
  localparam int RW = $clog2(NROW),
  localparam int CW = $clog2(NCOL)
) (
  input  logic                clock,
  input  logic                w_en_i,
  input  logic [RW-1:0]       w_row_i,
  input  logic [CW-1:0]       w_col_i,
  input  logic [8*ELEM_W-1:0] w_data_i,
  input  logic [RW-1:0]       rd_row_i,
  input  logic [CW-1:0]       rd_col_i,
  input  logic [CW-1:0]       rd_col_prev_i,
  output elem_t               rd_val_o,
  output elem_t               rd_prev_o
);

  elem_t mem [NROW][NCOL];

  // Segment write: byte k lands at the 8-aligned column base + k; out-of-range rows dropped.
  always_ff @(posedge clock) begin
    if (w_en_i && (32'(w_row_i) < NROW)) begin
      for (int k = 0; k < 8; k++)
        mem[w_row_i][{w_col_i[CW-1:3], 3'(k)}] <= w_data_i[k*ELEM_W +: ELEM_W];
    end
  end

  assign rd_val_o  = mem[rd_row_i][rd_col_i];
  assign rd_prev_o = mem[rd_row_i][rd_col_prev_i];

endmodule

// File: rtl/delta_input_buffer.sv
// delta_input_buffer: per-channel tile buffer that streams row-major beats of
// value and left-stride column delta to the delta PE array.
// Optional feature macro: DELTA_ZERO_SKIP_EN (drop non-first all-zero-delta beats,
// count them in skip_count).
module delta_input_buffer
  import delta_pkg::*;
#(
  parameter int NCH  = INPUT_CHANNEL,
  parameter int NROW = INPUT_HEIGHT,
  parameter int NCOL = INPUT_WIDTH,
  localparam int RW = $clog2(NROW),
  localparam int CW = $clog2(NCOL)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NCH-1:0]          IB_w_enable,
  input  logic [RW-1:0]           IB_SRAM_r,
  input  logic [CW-1:0]           IB_SRAM_c,
  input  logic [8*ELEM_W-1:0]     IB_w_data,
  input  logic                    start_stream,
  input  logic [2:0]              stride,
  input  logic [3:0]              kernel_size,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCH*ELEM_W-1:0]   out_value,
  output logic [NCH*(ELEM_W+1)-1:0] out_delta,
  output logic                    out_first,
  output logic [6:0]              out_r,
  output logic [6:0]              out_c,
  output logic                    busy,
  output logic                    done,
  output logic                    cfg_error
`ifdef DELTA_ZERO_SKIP_EN
  ,
  output logic [15:0]             skip_count
`endif
);

  ib_state_t state_q, state_d;
  logic [2:0]  stride_q;
  logic [6:0]  t_q;
  logic [RW-1:0] r_q;
  logic [CW-1:0] c_q;

  logic        out_valid_q, first_q, done_q, cfg_err_q;
  logic [6:0]  out_r_q, out_c_q;
  logic [NCH-1:0][ELEM_W-1:0] val_q;
  delta_t [NCH-1:0]           dlt_q;

  logic [NCH-1:0][ELEM_W-1:0] val_w;
  delta_t [NCH-1:0]           dlt_w;
  logic [6:0]    t_new;
  logic [2:0]    s_eff;
  logic          start_ok, first_w, last_w, load, skip;
  logic [CW-1:0] c_prev;

  assign t_new    = calc_t(stride, kernel_size);
  assign s_eff    = (stride == 3'd0) ? 3'd1 : stride;
  assign start_ok = (t_new != 7'd0) && (32'(t_new) <= NROW) && (32'(t_new) <= NCOL);
  assign first_w  = 7'(c_q) < {4'd0, stride_q};
  assign last_w   = (7'(r_q) == t_q - 7'd1) && (7'(c_q) == t_q - 7'd1);
  assign c_prev   = c_q - CW'(stride_q);

`ifdef DELTA_ZERO_SKIP_EN
  logic [NCH-1:0] dz_w;
  logic [15:0]    skip_cnt_q;
  assign skip_count = skip_cnt_q;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_bank
    elem_t cur, prev;
    delta_ib_bank #(.NROW(NROW), .NCOL(NCOL)) u_bank (
      .clock        (clock),
      .w_en_i       (IB_w_enable[g]),
      .w_row_i      (IB_SRAM_r),
      .w_col_i      (IB_SRAM_c),
      .w_data_i     (IB_w_data),
      .rd_row_i     (r_q),
      .rd_col_i     (c_q),
      .rd_col_prev_i(c_prev),
      .rd_val_o     (cur),
      .rd_prev_o    (prev)
    );
    assign val_w[g] = cur;
    // Columns left of the first stride have no neighbour: delta is the value itself.
    assign dlt_w[g] = first_w ? delta_t'({1'b0, cur}) : delta_t'({1'b0, cur} - {1'b0, prev});
`ifdef DELTA_ZERO_SKIP_EN
    assign dz_w[g] = (cur == prev);
`endif
  end

  // Next-state: beat load slot, zero-skip decision and stream termination.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    skip    = 1'b0;
    case (state_q)
      IDLE:   if (start_stream && start_ok) state_d = RUN;
      RUN: begin
        load = !out_valid_q || out_ready;
`ifdef DELTA_ZERO_SKIP_EN
        skip = load && !first_w && (&dz_w);
`endif
        if (load && last_w) state_d = skip ? FINISH : DRAIN;
      end
      DRAIN:  if (out_ready) state_d = FINISH;
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, counters and registered output beat.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      stride_q    <= '0;
      t_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      out_valid_q <= 1'b0;
      first_q     <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      out_r_q     <= '0;
      out_c_q     <= '0;
      val_q       <= '0;
      dlt_q       <= '0;
`ifdef DELTA_ZERO_SKIP_EN
      skip_cnt_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      done_q    <= (state_d == FINISH);
      cfg_err_q <= 1'b0;
      case (state_q)
        IDLE: if (start_stream) begin
          if (start_ok) begin
            stride_q <= s_eff;
            t_q      <= t_new;
            r_q      <= '0;
            c_q      <= '0;
          end else begin
            cfg_err_q <= 1'b1;
            done_q    <= 1'b1;
          end
`ifdef DELTA_ZERO_SKIP_EN
          skip_cnt_q <= '0;
`endif
        end
        RUN: if (load) begin
          out_valid_q <= !skip;
          val_q       <= val_w;
          dlt_q       <= dlt_w;
          first_q     <= first_w;
          out_r_q     <= 7'(r_q);
          out_c_q     <= 7'(c_q);
`ifdef DELTA_ZERO_SKIP_EN
          if (skip) skip_cnt_q <= skip_cnt_q + 16'd1;
`endif
          if (7'(c_q) == t_q - 7'd1) begin
            c_q <= '0;
            r_q <= r_q + 1'b1;
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        DRAIN: if (out_ready) out_valid_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign out_value = val_q;
  assign out_delta = dlt_q;
  assign out_first = first_q;
  assign out_r     = out_r_q;
  assign out_c     = out_c_q;
  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = done_q;
  assign cfg_error = cfg_err_q;

endmodule

// File: tb/tb_delta_input_buffer.sv
// tb_delta_input_buffer: directed + randomized streams against a behavioural
// tile model; a second instance with 32 rows covers configuration rejection.
module tb_delta_input_buffer;
  import delta_pkg::*;

  localparam int CH = INPUT_CHANNEL;
  localparam int H  = INPUT_HEIGHT;
  localparam int W  = INPUT_WIDTH;
  localparam int RW = $clog2(H);
  localparam int CW = $clog2(W);

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [CH-1:0] IB_w_enable = '0;
  logic [RW-1:0] IB_SRAM_r = '0;
  logic [CW-1:0] IB_SRAM_c = '0;
  logic [63:0]   IB_w_data = '0;
  logic          start_stream = 1'b0;
  logic [2:0]    stride = '0;
  logic [3:0]    kernel_size = '0;
  logic          out_ready = 1'b0;

  logic             out_valid, out_first, busy, done, cfg_error;
  logic [CH*8-1:0]  out_value;
  logic [CH*9-1:0]  out_delta;
  logic [6:0]       out_r, out_c;
  logic             out_valid2, out_first2, busy2, done2, cfg_error2;
  logic [CH*8-1:0]  out_value2;
  logic [CH*9-1:0]  out_delta2;
  logic [6:0]       out_r2, out_c2;
`ifdef DELTA_ZERO_SKIP_EN
  logic [15:0] skip_count, skip_count2;
`endif

  delta_input_buffer dut (
    .clock(clock), .reset(reset), .IB_w_enable(IB_w_enable), .IB_SRAM_r(IB_SRAM_r),
    .IB_SRAM_c(IB_SRAM_c), .IB_w_data(IB_w_data), .start_stream(start_stream),
    .stride(stride), .kernel_size(kernel_size), .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_delta(out_delta), .out_first(out_first), .out_r(out_r),
    .out_c(out_c), .busy(busy), .done(done), .cfg_error(cfg_error)
`ifdef DELTA_ZERO_SKIP_EN
    , .skip_count(skip_count)
`endif
  );

  delta_input_buffer #(.NROW(32)) dut2 (
    .clock(clock), .reset(reset), .IB_w_enable(IB_w_enable), .IB_SRAM_r(IB_SRAM_r[4:0]),
    .IB_SRAM_c(IB_SRAM_c), .IB_w_data(IB_w_data), .start_stream(start_stream),
    .stride(stride), .kernel_size(kernel_size), .out_valid(out_valid2), .out_ready(1'b1),
    .out_value(out_value2), .out_delta(out_delta2), .out_first(out_first2), .out_r(out_r2),
    .out_c(out_c2), .busy(busy2), .done(done2), .cfg_error(cfg_error2)
`ifdef DELTA_ZERO_SKIP_EN
    , .skip_count(skip_count2)
`endif
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] sh [CH][H][W];
  logic [63:0] cap_v [2];
  logic [63:0] cap_d [2];
  logic        cap_f [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [CH-1:0] m, input int r, input int c, input logic [63:0] d);
    IB_w_enable = m; IB_SRAM_r = RW'(r); IB_SRAM_c = CW'(c); IB_w_data = d;
    if (r < H)
      for (int ch = 0; ch < CH; ch++)
        if (m[ch])
          for (int k = 0; k < 8; k++) sh[ch][r][(c & ~7) + k] = d[k*8 +: 8];
    @(negedge clock);
    IB_w_enable = '0;
  endtask

  function automatic logic [63:0] exp_value(input int r, input int c);
    logic [63:0] v;
    v = '0;
    for (int ch = 0; ch < CH; ch++) v[ch*8 +: 8] = sh[ch][r][c];
    return v;
  endfunction

  function automatic logic [63:0] exp_delta(input int r, input int c, input int se);
    logic [63:0] d;
    int x;
    d = '0;
    for (int ch = 0; ch < CH; ch++) begin
      x = int'(sh[ch][r][c]);
      if (c >= se) x = x - int'(sh[ch][r][c - se]);
      d[ch*9 +: 9] = 9'(x);
    end
    return d;
  endfunction

  task automatic run_stream(input int s, input int k, input int stall_at, input int stall_len,
                            output int nbeats);
    int se, T, n, cyc, stall_left, er, ec;
    bit got_done, held, sk;
    logic [63:0] hv, hd;
    logic [6:0] hr, hc;
    logic hf;
    int q[$];
    se = (s == 0) ? 1 : s;
    T  = 7 * se + k;
    for (int r = 0; r < T; r++)
      for (int c = 0; c < T; c++) begin
        sk = 1'b0;
`ifdef DELTA_ZERO_SKIP_EN
        if (c >= se) begin
          sk = 1'b1;
          for (int ch = 0; ch < CH; ch++) if (sh[ch][r][c] != sh[ch][r][c - se]) sk = 1'b0;
        end
`endif
        if (!sk) q.push_back(r * 128 + c);
      end
    out_ready = 1'b0; stride = 3'(s); kernel_size = 4'(k); start_stream = 1'b1;
    @(negedge clock);
    start_stream = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_valid", out_valid, 0);
    chk("start_cfgerr", cfg_error, 0);
    chk("cfg2_err", cfg_error2, (T > 32));
    chk("cfg2_done", done2, (T > 32));
    n = 0; cyc = 0; got_done = 0; held = 0; stall_left = stall_len;
    hv = '0; hd = '0; hr = '0; hc = '0; hf = 1'b0;
    while (!got_done && cyc < T * T * 8 + 50) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) chk("latency_valid", out_valid, 1);
      if (cyc == 1 && T > 32) chk("cfg2_novalid", out_valid2, 0);
      if (held) begin
        chk("hold_value", out_value, hv);
        chk("hold_delta", out_delta, hd);
        chk("hold_r", out_r, hr);
        chk("hold_c", out_c, hc);
        chk("hold_first", out_first, hf);
      end
      if (done) begin
        got_done = 1;
        chk("done_busy", busy, 0);
        chk("done_valid", out_valid, 0);
      end else begin
        if (out_valid && n == stall_at && stall_left > 0) begin
          out_ready = 1'b0;
          stall_left--;
        end else begin
          out_ready = ($urandom_range(0, 3) != 0);
        end
        held = out_valid && !out_ready;
        hv = out_value; hd = out_delta; hr = out_r; hc = out_c; hf = out_first;
        if (out_valid && out_ready) begin
          if (n < q.size()) begin
            er = q[n] / 128; ec = q[n] % 128;
            chk("beat_r", out_r, er);
            chk("beat_c", out_c, ec);
            chk("beat_value", out_value, exp_value(er, ec));
            chk("beat_delta", out_delta, exp_delta(er, ec, se));
            chk("beat_first", out_first, (ec < se));
          end else begin
            chk("extra_beat", n, q.size());
          end
          if (n < 2) begin cap_v[n] = out_value; cap_d[n] = out_delta; cap_f[n] = out_first; end
          n++;
        end
      end
    end
    chk("done_seen", got_done, 1);
    chk("beat_count", n, q.size());
`ifdef DELTA_ZERO_SKIP_EN
    chk("skip_count", skip_count, T * T - q.size());
`endif
    @(negedge clock);
    chk("done_pulse_len", done, 0);
    nbeats = n;
  endtask

  initial begin
    int nb, n, cyc;
    repeat (3) @(negedge clock);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfgerr", cfg_error, 0);
    chk("rst_value", out_value, 0);
    chk("rst_delta", out_delta, 0);
    chk("rst_rc", {out_r, out_c}, 0);
    reset = 1'b0;
    @(negedge clock);

    for (int ch = 0; ch < CH; ch++)
      for (int r = 0; r < H; r++)
        for (int sg = 0; sg < W / 8; sg++)
          wr(CH'(1 << ch), r, sg * 8, {$urandom, $urandom});

    // column low bits ignored: c=5 lands on columns 0..7
    wr(4'b0001, 0, 5, 64'h0807060504030201);
    wr(4'b0010, 0, 0, 64'h0000000000000A0F);
    run_stream(1, 1, -1, 0, nb);
    chk("t1_b0_val", cap_v[0][7:0], 8'd1);
    chk("t1_b0_delta", cap_d[0][8:0], 9'd1);
    chk("t1_b0_first", cap_f[0], 1);
    chk("t1_b1_val", cap_v[1][7:0], 8'd2);
    chk("t1_b1_delta", cap_d[1][8:0], 9'd1);
    chk("t1_b1_first", cap_f[1], 0);
    chk("t2_ch1_delta", cap_d[1][17:9], 9'h1FB);

    run_stream(2, 3, 10, 5, nb);
`ifndef DELTA_ZERO_SKIP_EN
    chk("t3_beats", nb, 289);
`endif
    run_stream(0, 5, 20, 3, nb);
    run_stream(7, 15, 100, 2, nb);
`ifndef DELTA_ZERO_SKIP_EN
    chk("t4_beats", nb, 4096);
`endif
    run_stream(3, 0, -1, 0, nb);

    // mid-stream reset
    stride = 3'd1; kernel_size = 4'd1; out_ready = 1'b1; start_stream = 1'b1;
    @(negedge clock);
    start_stream = 1'b0;
    n = 0; cyc = 0;
    while (n < 20 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (out_valid) n++;
    end
    chk("rst_mid_reach", n, 20);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("rst_mid_valid", out_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_rc", {out_r, out_c}, 0);
    @(negedge clock);
    chk("rst_mid_nodone", done, 0);
    run_stream(1, 1, -1, 0, nb);

    // constant fill across all banks in one multi-bank write per row
    for (int r = 0; r < 8; r++) wr('1, r, 0, {8{8'h33}});
    run_stream(1, 1, -1, 0, nb);
`ifdef DELTA_ZERO_SKIP_EN
    chk("const_beats", nb, 8);
    chk("const_skip", skip_count, 56);
`else
    chk("const_beats", nb, 64);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/delta_input_buffer.md
Name: delta_input_buffer

Overview:
Per-channel input tile buffer sitting directly downstream of the input loader.
- Write side: accepts 8-byte row segments from the loader's buffer-load phase, up to INPUT_CHANNEL channels.
- Read side: streams the tile row-major to the delta PE array. Each beat carries, for every channel, the element value and its column delta against the element `stride` columns earlier (the DeltaNN delta operand).

Parameters:
INPUT_CHANNEL, 4, channels held (one bank each)
INPUT_HEIGHT, 64, tile rows per bank
INPUT_WIDTH, 64, tile columns per bank (multiple of 8)
ELEM_W, 8, element width in bits (unsigned)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
IB_w_enable  in  INPUT_CHANNEL  per-channel write strobe
IB_SRAM_r  in  clog2(INPUT_HEIGHT)  write row
IB_SRAM_c  in  clog2(INPUT_WIDTH)  write column, 8-aligned
IB_w_data  in  8*ELEM_W  eight elements; byte k goes to column c+k
start_stream  in  1  one-cycle start pulse
stride  in  3  convolution stride
kernel_size  in  4  kernel edge
out_valid  out  1  output beat valid
out_ready  in  1  consumer accept
out_value  out  INPUT_CHANNEL*ELEM_W  element per channel, ch0 in LSBs
out_delta  out  INPUT_CHANNEL*(ELEM_W+1)  signed value minus left-stride neighbour
out_first  out  1  beat has c < stride (delta = value)
out_r, out_c  out  7 each  tile coordinate of beat
busy  out  1  stream in progress
done  out  1  one-cycle pulse after last beat accepted
cfg_error  out  1  one-cycle pulse, start rejected

Behaviour:
- Reset values:
  - All outputs and counters are 0; FSM goes to IDLE.
  - Storage arrays are not reset. The bench must not read unwritten locations.
- Write path:
  - Any cycle, every channel whose IB_w_enable bit is set stores IB_w_data at row r, columns {c[hi:3],3'b0}+0..7.
  - IB_SRAM_c[2:0] is ignored.
  - Multiple enable bits write all selected banks.
  - Writes with r >= INPUT_HEIGHT are dropped. Writes are accepted in every state.
- Start / configuration:
  - start_stream is sampled only in IDLE and ignored otherwise.
  - On start, latch stride_eff (stride, with 0 treated as 1) and kernel_size.
  - T = (stride_eff<<3) - stride_eff + kernel_size, 7 bits.
  - If T == 0 or T > INPUT_HEIGHT or T > INPUT_WIDTH: pulse cfg_error and done in the next cycle, stay IDLE.
- FSM states: IDLE -> RUN -> DRAIN -> FINISH -> IDLE.
  - RUN: a beat is loaded when (!out_valid || out_ready), giving a throughput of 1 beat/cycle.
  - Beat loading registers value = bank[ch][r][c]. Delta = value - bank[ch][r][c-stride_eff], sign-extended to ELEM_W+1.
  - For c < stride_eff: delta = {0,value} and out_first = 1.
  - Counters advance c++. At c == T-1: c = 0, r++.
  - Loading the beat at (T-1, T-1) moves the FSM to DRAIN.
  - DRAIN: hold out_* stable while out_valid && !out_ready. On acceptance, go to FINISH.
  - FINISH: done = 1 for one cycle, busy = 0, return to IDLE.
  - busy = 1 in RUN and DRAIN.
- Latency: first out_valid asserts 2 cycles after start_stream (1 cycle latch, 1 cycle load).
- Backpressure: out_* must not change while out_valid && !out_ready. Total beats per stream is exactly T*T.
- Read/write collision: a write in the same cycle as a beat load to the same location returns the old data (read-before-write).
- Reset asserted mid-stream aborts immediately. No done pulse; all outputs go to 0 the next cycle.

Optional Feature:
DELTA_ZERO_SKIP_EN
- Defined:
  - A non-first beat whose deltas are all zero across every channel is not presented. Counters advance in the same cycle.
  - A 16-bit output skip_count increments per skipped beat. It clears on start_stream.
  - If the final (T-1, T-1) beat is skipped, go directly to FINISH.
- Undefined: skip_count is absent and all T*T beats are emitted.

Decomposition:
- Package delta_pkg holds:
  - INPUT_CHANNEL, INPUT_HEIGHT, INPUT_WIDTH, ELEM_W constants.
  - elem_t and delta_t (signed ELEM_W+1) typedefs.
  - The ib_state_t enum {IDLE, RUN, DRAIN, FINISH}.
  - A function computing T from stride and kernel_size.
- Sub-module delta_ib_bank: one channel's storage, with one 64-bit write port and two combinational element read ports (c and c-stride). Instantiated INPUT_CHANNEL times via generate.

Test Plan:
- Write ch0 r0 c0 = 0x0807060504030201; stream stride=1 kernel=1 (T=8) -> beat (0,0) value 1 delta 1 out_first=1; beat (0,1) value 2 delta 1 out_first=0; 64 beats then done pulse.
- ch1 r0 c0 = 0x0000000000000A0F; stride=1, kernel=1 -> beat (0,1) delta on ch1 = -5 (9'h1FB).
- stride=2 kernel=3 (T=17): hold out_ready=0 for 5 cycles at beat 10 -> outputs stable; 289 beats total; out_first=1 only for c in {0,1}.
- stride=7 kernel=15 (T=64) -> accepted, 4096 beats. stride=7 kernel=15 with INPUT_HEIGHT=32 -> cfg_error and done 1 cycle after start, no out_valid.
- Reset at beat 20 of a T=8 stream -> busy/out_valid 0 next cycle, no done. A new start afterwards streams from (0,0).
- DELTA_ZERO_SKIP_EN, all banks filled with constant 0x33, T=8 -> only the 8 out_first beats (c=0 of each row) are emitted, skip_count = 56.
